switch_port_rx: RTL
===================

Name: switch_port_rx

Overview:
- Link-side receiver attached to one switch output port. This is the consumer end of the switch's out / data_ready_out / packet_sent / credit_granted interface.
- Captures flits presented by the switch and acknowledges each with packet_sent.
- Buffers flits per virtual channel (VC) and hands them to a downstream valid/ready consumer.
- Returns one credit_granted pulse per VC each time a buffered flit on that VC is drained.

Parameters:
- NUM_VCS, 2, number of virtual channels; one FIFO and one credit line per VC.
- BUFFER_SIZE, 8, per-VC FIFO depth in flits. Must be a power of two and at least 2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- in_flit  input  chiplet_types_pkg::flit_t  flit from the switch output port. The VC is taken from field in_flit.vc.
- data_ready_in  input  1  switch is presenting a valid flit. Held with in_flit stable until packet_sent is seen.
- packet_sent  output  1  one-cycle acknowledge that the presented flit was captured.
- credit_granted  output  NUM_VCS  per-VC one-cycle credit return pulse.
- out_flit  output  chiplet_types_pkg::flit_t  head flit of the VC currently selected by the arbiter.
- out_valid  output  1  out_flit is valid.
- out_ready  input  1  downstream accepts out_flit. The pop happens when out_valid && out_ready.
- overflow_err  output  1  sticky: a flit arrived for a full VC.

Behaviour:
- Reset (rst high at a clk edge):
  - All FIFOs emptied; count, read pointer and write pointer all 0.
  - FSM goes to IDLE.
  - packet_sent=0, credit_granted=0, overflow_err=0.
  - Arbiter pointer=0.
  - out_valid=0 from the first cycle after reset.
  - Reset asserted mid-handshake discards all buffered flits and the pending ACK. No credits are returned for discarded flits.
- Capture FSM:
  - IDLE:
    - If data_ready_in=1 and count[in_flit.vc] < BUFFER_SIZE: write in_flit into that VC FIFO at this edge, then go to ACK.
    - If data_ready_in=1 and the VC is full: set overflow_err, do not write, do not ack, stay in IDLE.
  - ACK:
    - packet_sent=1 for exactly this one cycle; data_ready_in is ignored.
    - Next state is IDLE.
  - Resulting rate: at most one flit per 2 cycles. Capture-to-packet_sent latency is 1 cycle.
- Drain side:
  - out_valid=1 iff any VC count is nonzero.
  - Selection is round-robin: first nonempty VC at or after arb_ptr, searching upward and wrapping.
  - out_flit is taken combinationally from the selected VC FIFO head.
  - On a pop: read pointer and count of that VC update at the edge, and arb_ptr becomes (selected VC + 1) mod NUM_VCS.
  - If out_valid=0 or out_ready=0, arb_ptr holds.
  - out_flit is don't-care when out_valid=0; the bench must not check it then.
- Credits:
  - credit_granted[v] is registered and goes high the cycle after a pop on VC v, for one cycle.
  - At most one credit per cycle overall, since there is at most one pop per cycle.
- Simultaneous push and pop on the same VC in one cycle:
  - Both take effect; count is unchanged.
  - Full is evaluated on the pre-edge count, so a push into a full VC is rejected even if a pop happens in the same cycle. That case raises overflow_err.
- Pointers are log2(BUFFER_SIZE) bits and wrap naturally. Count is log2(BUFFER_SIZE)+1 bits.
- overflow_err clears only on reset.

Optional Feature:
- Macro: SWITCH_PORT_RX_STATS_EN.
- When defined:
  - Adds output rx_flit_count, 16 bits: total flits captured since reset.
  - Increments on each IDLE capture and wraps 0xFFFF -> 0x0000.
  - Reset value is 0.
  - Overflow drops do not count.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Single flit: reset, then present one flit on vc=1 with data_ready_in held.
  - packet_sent high exactly 1 cycle after capture.
  - out_valid=1 with matching out_flit.
  - Pulse out_ready → credit_granted=2'b10 one cycle later.
- Fill VC0 with 8 flits while out_ready=0, then present a 9th.
  - No packet_sent for the 9th; overflow_err=1 and stays 1.
  - Drain with out_ready=1 → 8 flits in order, 8 credit pulses on bit 0.
- Round-robin: 3 flits in VC0 and 3 in VC1, out_ready held high.
  - Pop order is VC0,VC1,VC0,VC1,VC0,VC1.
  - credit_granted alternates 01,10,...
- Simultaneous push and pop on VC0 at count=4 → count stays 4 and FIFO order is preserved. The same at count=8 → push rejected and overflow_err=1.
- Reset during ACK with 3 flits buffered.
  - packet_sent=0 the next cycle, out_valid=0, no credit pulses.
  - A following flit is captured normally.
- With SWITCH_PORT_RX_STATS_EN defined:
  - Capture 5 flits → rx_flit_count=5.
  - Preload the counter via forced state to 0xFFFF and capture one more flit → 0x0000.

Source files
------------

// File: rtl/switch_port_rx.sv
`default_nettype none
// ============================================================================
//  Module      : switch_port_rx (with flit type package chiplet_types_pkg)
//  Description : Link-side receiver for one switch output port. Captures flits
//                with a two-state ACK handshake, buffers them per virtual
//                channel, drains them round-robin to a valid/ready consumer
//                and returns one credit per drained flit.
//                Optional build macro SWITCH_PORT_RX_STATS_EN adds the 16-bit
//                rx_flit_count capture counter.
//  Revision    : 1.0  initial release
// ============================================================================

package chiplet_types_pkg;
    localparam int VC_W      = 2;
    localparam int PAYLOAD_W = 32;

    typedef struct packed {
        logic                 head;
        logic                 tail;
        logic [VC_W-1:0]      vc;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;
endpackage

module switch_port_rx
    import chiplet_types_pkg::*;
#(
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  flit_t              in_flit,
    input  logic               data_ready_in,
    output logic               packet_sent,
    output logic [NUM_VCS-1:0] credit_granted,
    output flit_t              out_flit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overflow_err
`ifdef SWITCH_PORT_RX_STATS_EN
    ,
    output logic [15:0]        rx_flit_count
`endif
);

    localparam int c_PTR_W = $clog2(BUFFER_SIZE);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_VC_W  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    flit_t                r_mem    [NUM_VCS][BUFFER_SIZE];
    logic [c_PTR_W-1:0]   r_wr_ptr [NUM_VCS];
    logic [c_PTR_W-1:0]   r_rd_ptr [NUM_VCS];
    logic [c_CNT_W-1:0]   r_cnt    [NUM_VCS];

    logic [c_VC_W-1:0]    r_arb_ptr;
    logic [NUM_VCS-1:0]   r_credit;
    logic                 r_ovf;

    logic [c_VC_W-1:0]    w_in_vc;
    logic                 w_vc_ok;
    logic                 w_in_full;
    logic                 w_push;
    logic                 w_ovf_set;
    logic [c_VC_W-1:0]    w_sel;
    logic                 w_any;
    logic                 w_pop;
    logic [NUM_VCS-1:0]   w_push_vec;
    logic [NUM_VCS-1:0]   w_pop_vec;

    function automatic logic [c_VC_W-1:0] vc_add(input logic [c_VC_W-1:0] base, input int off);
        return c_VC_W'((int'(base) + off) % NUM_VCS);
    endfunction

    // A VC number outside the configured range is treated like a full VC:
    // the flit is dropped, never acknowledged, and flagged as an overflow.
    assign w_in_vc   = c_VC_W'(in_flit.vc);
    assign w_vc_ok   = (int'(in_flit.vc) < NUM_VCS);
    assign w_in_full = (r_cnt[w_in_vc] == c_CNT_W'(BUFFER_SIZE));

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_ovf_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (data_ready_in) begin
                    if (w_vc_ok && !w_in_full) begin
                        w_push      = 1'b1;
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_ovf_set   = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Scan from the farthest offset back to arb_ptr so the nearest nonempty VC wins.
    always_comb begin
        w_sel = r_arb_ptr;
        w_any = 1'b0;
        for (int i = NUM_VCS - 1; i >= 0; i--) begin
            if (r_cnt[vc_add(r_arb_ptr, i)] != '0) begin
                w_sel = vc_add(r_arb_ptr, i);
                w_any = 1'b1;
            end
        end
    end

    assign w_pop = w_any && out_ready;

    always_comb begin
        w_push_vec = '0;
        w_pop_vec  = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            w_push_vec[v] = w_push && (w_in_vc == c_VC_W'(v));
            w_pop_vec[v]  = w_pop  && (w_sel   == c_VC_W'(v));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_in_vc][r_wr_ptr[w_in_vc]] <= in_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_cnt[v]    <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (w_push_vec[v]) begin
                    r_wr_ptr[v] <= r_wr_ptr[v] + c_PTR_W'(1);
                end
                if (w_pop_vec[v]) begin
                    r_rd_ptr[v] <= r_rd_ptr[v] + c_PTR_W'(1);
                end
                case ({w_push_vec[v], w_pop_vec[v]})
                    2'b10:   r_cnt[v] <= r_cnt[v] + c_CNT_W'(1);
                    2'b01:   r_cnt[v] <= r_cnt[v] - c_CNT_W'(1);
                    default: r_cnt[v] <= r_cnt[v];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_arb_ptr <= '0;
            r_credit  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_arb_ptr <= vc_add(w_sel, 1);
            end
            r_credit <= w_pop_vec;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef SWITCH_PORT_RX_STATS_EN
    logic [15:0] r_rx_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_cnt <= '0;
        end else if (w_push) begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
        end
    end

    assign rx_flit_count = r_rx_cnt;
`endif

    assign packet_sent    = (r_state == ST_ACK);
    assign credit_granted = r_credit;
    assign overflow_err   = r_ovf;
    assign out_valid      = w_any;
    assign out_flit       = r_mem[w_sel][r_rd_ptr[w_sel]];

endmodule

`default_nettype wire
